// File: rtl/pipe_rr_sched_pkg.sv
// Shared constants and types for the round-robin pipe scheduler.
// Holds pipe latency, default output buffer depth and the source-index encoding.
package pipe_rr_sched_pkg;

  localparam int unsigned PIPE_LATENCY       = 2;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic {
    SRC_REQ0 = 1'b0,
    SRC_REQ1 = 1'b1
  } src_e;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  function automatic src_e rr_pick(input logic v0, input logic v1, input src_e last_grant);
    if (v0 && v1)
      return (last_grant == SRC_REQ0) ? SRC_REQ1 : SRC_REQ0;
    else if (v1)
      return SRC_REQ1;
    else
      return SRC_REQ0;
  endfunction

endpackage

// File: rtl/pipe_out_fifo.sv
// First-word fall-through output buffer for the scheduler pipe.
// Push and pop may coincide at any occupancy; pointers wrap modulo DEPTH.
module pipe_out_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_rr_sched.sv
// Two requesters share a fixed, non-stallable register pipe arbitrated round-robin;
// a credit counter guarantees the pipe never overruns the output FIFO.
module pipe_rr_sched
  import pipe_rr_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAST = PIPE_LATENCY - 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

  src_e                    last_grant;
  src_e                    winner;
  logic [CW-1:0]           credit;
  logic                    grant_ok;
  logic                    accept;
  logic                    pop;
  logic [WIDTH-1:0]        win_data;
  logic [PIPE_LATENCY-1:0] stg_valid;
  logic [WIDTH-1:0]        stg_data [PIPE_LATENCY];
  src_e                    stg_src  [PIPE_LATENCY];
  logic [WIDTH:0]          fifo_head;
  logic                    fifo_empty;

  assign winner   = rr_pick(req0_valid, req1_valid, last_grant);
  assign win_data = (winner == SRC_REQ1) ? req1_data : req0_data;

  // Gated by rst_n so readies drop the moment reset asserts, not at the next edge.
  assign grant_ok   = rst_n && (credit != '0);
  assign req0_ready = grant_ok && req0_valid && (winner == SRC_REQ0);
  assign req1_ready = grant_ok && req1_valid && (winner == SRC_REQ1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_head[WIDTH-1:0] : '0;
  assign out_src   = out_valid && fifo_head[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_REQ1;
    end else if (accept) begin
      last_grant <= winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CREDIT_MAX;
    end else begin
      case ({accept, pop})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   credit <= credit + 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      for (int unsigned i = 0; i < PIPE_LATENCY; i++) begin
        stg_data[i] <= '0;
        stg_src[i]  <= SRC_REQ0;
      end
    end else begin
      stg_valid[0] <= accept;
      stg_data[0]  <= win_data;
      stg_src[0]   <= winner;
      for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_data[i]  <= stg_data[i-1];
        stg_src[i]   <= stg_src[i-1];
      end
    end
  end

  pipe_out_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stg_valid[LAST]),
    .push_data ({logic'(stg_src[LAST]), stg_data[LAST]}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Bench for pipe_rr_sched: directed table, corner-case sequences and random traffic
// checked against a queue model of accepted-but-not-yet-delivered items.
module tb_pipe_rr_sched;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_data = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_data = '0;
  logic         req1_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_ready = 1'b0;

  always #5 clk = ~clk;

  pipe_rr_sched #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         src;
    int           avail;
  } item_t;

  typedef struct {
    logic         r0;
    logic         r1;
    logic         ov;
    logic [W-1:0] od;
    logic         os;
    logic         acc;
    logic         popd;
  } obs_t;

  typedef struct {
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         ordy;
    logic         r0;
    logic         r1;
    logic         ov;
    logic [W-1:0] od;
    logic         os;
  } vec_t;

  // Items in flight (pipe + FIFO) in accept order; avail = first cycle visible at the output.
  item_t q[$];
  int    cyc = 0;
  int    last_g = 1;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dut.u_fifo.push) begin
      checks++;
      if (dut.u_fifo.full && !dut.u_fifo.pop) begin
        errors++;
        $display("FAIL fifo_overflow: push into full FIFO without pop (cycle %0d)", cyc);
      end
    end
  end

  task automatic step(input logic v0, input logic [W-1:0] d0, input logic v1,
                      input logic [W-1:0] d1, input logic ordy, output obs_t o);
    logic  r0, r1, ov;
    item_t it;
    @(negedge clk);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    out_ready  = ordy;
    #1;
    o.r0 = req0_ready; o.r1 = req1_ready; o.ov = out_valid; o.od = out_data; o.os = out_src;
    ov = (q.size() > 0) && (q[0].avail <= cyc);
    r0 = 1'b0;
    r1 = 1'b0;
    if (q.size() < D) begin
      if (v0 && v1) begin
        if (last_g == 1) r0 = 1'b1; else r1 = 1'b1;
      end else if (v0) r0 = 1'b1;
      else if (v1) r1 = 1'b1;
    end
    chk("out_valid", out_valid, ov);
    if (ov) begin
      chk("out_data", out_data, q[0].data);
      chk("out_src", out_src, q[0].src);
    end
    chk("req0_ready", req0_ready, r0);
    chk("req1_ready", req1_ready, r1);
    chk("credit", dut.credit, D - q.size());
    o.acc  = r0 | r1;
    o.popd = ov & ordy;
    @(posedge clk);
    cyc++;
    if (o.popd) void'(q.pop_front());
    if (o.acc) begin
      it.data  = r0 ? d0 : d1;
      it.src   = r1;
      it.avail = cyc + 2;
      q.push_back(it);
      last_g = r1 ? 1 : 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_src", out_src, 0);
    chk("rst req0_ready", req0_ready, 0);
    chk("rst req1_ready", req1_ready, 0);
    chk("rst credit", dut.credit, D);
    q.delete();
    last_g = 1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];

  initial begin
    obs_t         o;
    int           n_acc;
    int           pop_cyc;
    logic [W-1:0] d;

    // Alternating grants with both requesters continuously valid, starting from reset.
    tbl[0] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[2] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[3] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0};
    tbl[4] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2, 1'b1};
    tbl[5] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0};
    tbl[6] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1};
    tbl[7] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
    tbl[8] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1};
    tbl[9] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy, o);
      chk("tbl r0", o.r0, tbl[i].r0);
      chk("tbl r1", o.r1, tbl[i].r1);
      chk("tbl ov", o.ov, tbl[i].ov);
      if (tbl[i].ov) begin
        chk("tbl od", o.od, tbl[i].od);
        chk("tbl os", o.os, tbl[i].os);
      end
    end

    // Single item latency: visible two edges after accept, held one cycle.
    do_reset();
    step(1'b1, 4'h3, 1'b0, 4'h0, 1'b1, o);
    chk("lat accept", o.r0, 1);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, o);
    chk("lat ov T", o.ov, 0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, o);
    chk("lat ov T+1", o.ov, 0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, o);
    chk("lat ov T+2", o.ov, 1);
    chk("lat od", o.od, 4'h3);
    chk("lat os", o.os, 0);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, o);
    chk("lat ov T+3", o.ov, 0);

    // Backpressure until credit runs out, one-cycle pop pulse, then resumed streaming.
    do_reset();
    n_acc = 0;
    d = 4'h1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, d, 1'b0, 4'h0, 1'b0, o);
      if (o.r0) begin
        n_acc++;
        d++;
      end
    end
    chk("stall accepts", n_acc, 4);
    chk("stall ready low", o.r0, 0);
    step(1'b1, d, 1'b0, 4'h0, 1'b1, o);
    chk("pulse ready low", o.r0, 0);
    chk("pulse pop", o.ov, 1);
    pop_cyc = cyc;
    #1 chk("credit after pulse", dut.credit, 1);
    step(1'b1, d, 1'b0, 4'h0, 1'b1, o);
    chk("resume ready", o.r0, 1);
    chk("resume cycle", cyc, pop_cyc + 1);
    if (o.r0) d++;
    #1 chk("credit accept+pop", dut.credit, 1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, d, 1'b0, 4'h0, 1'b1, o);
      if (o.r0) d++;
    end

    // Reset with one item buffered and two in the pipe discards them all.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 7), 1'b0, 4'h0, 1'b0, o);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, o);

    // Random traffic with a reset in the middle.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
           ($urandom_range(0, 9) < 7), o);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, o);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
